// File: rtl/reg5_arbiter_pkg.sv
// Shared definitions for the three-requester arbiter that feeds the 5-bit shared register.
// Holds the state encodings, default sizes and small index helpers.
package reg5_arbiter_pkg;

  localparam int N_REQ        = 3;
  localparam int DEF_WIDTH    = 5;
  localparam int DEF_HOLD_MAX = 8;

  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOAD     = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  // Requester index that is 'offset' positions after 'base', wrapping modulo N_REQ.
  function automatic idx_t wrap_idx(input idx_t base, input int offset);
    return idx_t'((int'(base) + offset) % N_REQ);
  endfunction

  function automatic idx_t onehot_to_idx(input logic [N_REQ-1:0] oh);
    idx_t r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/reg5_arbiter_rr_pick.sv
// Rotating-priority pick: the requester just after 'last' has top priority.
// Pure combinational; returns a one-hot winner, or zero when nothing is requested.
module rr_pick
  import reg5_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             last,
  output logic [N_REQ-1:0] winner
);

  idx_t cand;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = wrap_idx(last, i);
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg5_arbiter.sv
// Round-robin arbiter granting one of three requesters access to a shared register:
// one LOAD cycle drives ld, then the grant is held until release or a forced timeout.
module reg5_arbiter
  import reg5_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic [N_REQ-1:0] gnt,
  output logic             ld,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  state_t           state, state_next;
  logic [N_REQ-1:0] gnt_next;
  logic             ld_next;
  logic             timeout_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  idx_t             last, last_next;
  logic [N_REQ-1:0] pick;
  logic             owner_req;

  rr_pick u_rr_pick (
    .req    (req),
    .last   (last),
    .winner (pick)
  );

  assign owner_req = |(req & gnt);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      ld      <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= idx_t'(N_REQ - 1);
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      ld      <= ld_next;
      timeout <= timeout_next;
      cnt     <= cnt_next;
      last    <= last_next;
    end
  end

  // The registered outputs are computed one cycle ahead, alongside the next state.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    ld_next      = 1'b0;
    timeout_next = 1'b0;
    cnt_next     = cnt;
    last_next    = last;
    case (state)
      IDLE: begin
        gnt_next = '0;
        cnt_next = '0;
        if (|req) begin
          state_next = LOAD;
          gnt_next   = pick;
          ld_next    = 1'b1;
        end
      end
      LOAD: begin
        state_next = WAIT_REL;
        cnt_next   = '0;
      end
      WAIT_REL: begin
        // A voluntary release takes precedence over the hold limit.
        if (!owner_req) begin
          state_next = IDLE;
          gnt_next   = '0;
          last_next  = onehot_to_idx(gnt);
        end else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
          state_next   = IDLE;
          gnt_next     = '0;
          last_next    = onehot_to_idx(gnt);
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    data_out = '0;
    case (gnt)
      3'b001:  data_out = din0;
      3'b010:  data_out = din1;
      3'b100:  data_out = din2;
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_reg5_arbiter.sv
// Bench for reg5_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a grant-age reference model of the arbitration rules.
module tb_reg5_arbiter;

  localparam int WIDTH    = 5;
  localparam int HOLD_MAX = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [WIDTH-1:0] din_v [3];
  logic [WIDTH-1:0] din0, din1, din2;
  logic [2:0]       gnt;
  logic             ld;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             timeout;

  always #5 clk = ~clk;

  assign din0 = din_v[0];
  assign din1 = din_v[1];
  assign din2 = din_v[2];

  reg5_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din0     (din0),
    .din1     (din1),
    .din2     (din2),
    .gnt      (gnt),
    .ld       (ld),
    .data_out (data_out),
    .busy     (busy),
    .timeout  (timeout)
  );

  // The shared register the arbiter loads.
  logic [WIDTH-1:0] shared_q = '0;
  always @(posedge clk) if (ld) shared_q <= data_out;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = none), cycles since grant, last served, timeout pulse.
  int               m_owner = -1;
  int               m_age   = 0;
  int               m_last  = 2;
  bit               m_timeout = 1'b0;
  logic [WIDTH-1:0] m_reg = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep();
    bit found;
    int cand;
    if (m_owner >= 0 && m_age == 0) m_reg = din_v[m_owner];
    m_timeout = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_age   = 0;
      m_last  = 2;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        cand = (m_last + i) % 3;
        if (!found && req[cand]) begin
          found   = 1'b1;
          m_owner = cand;
          m_age   = 0;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_age == HOLD_MAX) begin
      m_last    = m_owner;
      m_owner   = -1;
      m_timeout = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  task automatic checkCycle(input string tag);
    logic [2:0]       exp_gnt;
    logic [WIDTH-1:0] exp_data;
    exp_gnt  = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    exp_data = (m_owner >= 0) ? din_v[m_owner] : '0;
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    checkOutput({tag, ".ld"}, 32'(ld), 32'(m_owner >= 0 && m_age == 0));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(m_timeout));
    checkOutput({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
    checkOutput({tag, ".reg"}, 32'(shared_q), 32'(m_reg));
    checkOutput({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    checkOutput({tag, ".ld_gnt"}, 32'(!ld || $onehot(gnt)), 32'd1);
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] rq, input string tag);
    rst = r;
    req = rq;
    @(posedge clk);
    modelStep();
    #1;
    checkCycle(tag);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 3'b000, "reset");
    applyStimulus(1'b1, 3'b000, "reset");
  endtask

  function automatic int gntIdx(input logic [2:0] g);
    return g[1] ? 1 : (g[2] ? 2 : 0);
  endfunction

  initial begin
    int     order [$];
    int     exp_order [4];
    int     wait_cnt;
    logic [2:0] rq;

    rst = 1'b1;
    req = 3'b000;
    for (int i = 0; i < 3; i++) din_v[i] = '0;

    // Reset state
    doReset();
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Single request loads its data
    din_v[0] = 5'b10101;
    din_v[1] = 5'b01110;
    din_v[2] = 5'b00011;
    applyStimulus(1'b0, 3'b001, "single");
    checkOutput("single_gnt", 32'(gnt), 32'b001);
    checkOutput("single_ld", 32'(ld), 32'd1);
    checkOutput("single_data", 32'(data_out), 32'b10101);
    applyStimulus(1'b0, 3'b001, "single");
    checkOutput("single_ld_off", 32'(ld), 32'd0);
    checkOutput("single_reg", 32'(shared_q), 32'b10101);
    applyStimulus(1'b0, 3'b000, "single");
    applyStimulus(1'b0, 3'b000, "single");

    // All request; each owner drops after two hold cycles
    doReset();
    exp_order = '{0, 1, 2, 0};
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      rq = 3'b111;
      if (m_owner >= 0 && m_age >= 2) rq[m_owner] = 1'b0;
      applyStimulus(1'b0, rq, "rr");
      if (ld) order.push_back(gntIdx(gnt));
    end
    checkOutput("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) checkOutput($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    end

    // Held request is forced off after HOLD_MAX cycles, then re-granted
    doReset();
    applyStimulus(1'b0, 3'b010, "hold");
    checkOutput("hold_ld", 32'(ld), 32'd1);
    wait_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 3'b010, "hold");
      if (timeout) break;
      wait_cnt++;
    end
    checkOutput("hold_wait_cycles", 32'(wait_cnt), 32'(HOLD_MAX));
    checkOutput("hold_timeout", 32'(timeout), 32'd1);
    applyStimulus(1'b0, 3'b010, "hold");
    checkOutput("hold_regrant_gnt", 32'(gnt), 32'b010);
    checkOutput("hold_regrant_ld", 32'(ld), 32'd1);
    checkOutput("hold_timeout_off", 32'(timeout), 32'd0);

    // Release on the limit cycle beats the timeout
    doReset();
    applyStimulus(1'b0, 3'b001, "limit");
    for (int c = 0; c < 20; c++) begin
      if (m_age == HOLD_MAX) break;
      applyStimulus(1'b0, 3'b001, "limit");
    end
    applyStimulus(1'b0, 3'b000, "limit");
    checkOutput("limit_busy", 32'(busy), 32'd0);
    checkOutput("limit_timeout", 32'(timeout), 32'd0);

    // Reset in the middle of a LOAD
    doReset();
    applyStimulus(1'b0, 3'b010, "rstload");
    applyStimulus(1'b0, 3'b010, "rstload");
    applyStimulus(1'b0, 3'b000, "rstload");
    applyStimulus(1'b0, 3'b000, "rstload");
    applyStimulus(1'b0, 3'b111, "rstload");
    checkOutput("rstload_pre_gnt", 32'(gnt), 32'b100);
    applyStimulus(1'b1, 3'b111, "rstload");
    checkOutput("rstload_gnt", 32'(gnt), 32'd0);
    checkOutput("rstload_ld", 32'(ld), 32'd0);
    checkOutput("rstload_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 3'b111, "rstload");
    checkOutput("rstload_next_gnt", 32'(gnt), 32'b001);

    // Random traffic
    rq = 3'b000;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 3; i++) din_v[i] = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom);
      applyStimulus($urandom_range(0, 63) == 0, rq, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
